writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The module SHALL have parameter DW, default 64, meaning the register data width.
REQ-002 The module SHALL have parameter AW, default 5, meaning the register address width (32 registers).
REQ-003 The module SHALL have parameter QDEPTH, default 2, meaning the load-result queue depth.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 alu_valid  input  1  ALU result present this cycle; no backpressure.
REQ-007 alu_rd  input  AW  ALU destination register.
REQ-008 alu_data  input  DW  ALU result.
REQ-009 ld_valid  input  1  load result offered.
REQ-010 ld_ready  output  1  load result accepted when ld_valid and ld_ready are both high.
REQ-011 ld_rd  input  AW  load destination register.
REQ-012 ld_data  input  DW  load result.
REQ-013 chk_rd  input  AW  register queried for pending writes.
REQ-014 chk_pending  output  1  chk_rd has a queued, not-yet-written load result.
REQ-015 write  output  1  register-file write enable.
REQ-016 regwriteaddress  output  AW  register-file write address.
REQ-017 datain  output  DW  register-file write data.

Function
REQ-018 The load queue SHALL be a FIFO of QDEPTH entries (valid, rd, data) with an occupancy count 0..QDEPTH.
REQ-019 ld_ready SHALL be combinational: high iff count < QDEPTH; a push while full SHALL NOT occur.
REQ-020 Each cycle, the selector SHALL choose the ALU result if alu_valid, else the FIFO head if count > 0, else nothing.
REQ-021 write, regwriteaddress and datain SHALL be registered: the choice made in cycle N appears in cycle N+1.
REQ-022 ALU latency SHALL be exactly 1 cycle; an ALU result is never delayed.
REQ-023 The FIFO head SHALL pop only in a cycle where alu_valid is low; load latency is at least 2 cycles (push, then pop; no bypass).
REQ-024 When a push and a pop occur in the same cycle, count SHALL be unchanged and FIFO order SHALL be preserved.
REQ-025 A result with rd == 0 SHALL be consumed normally but SHALL produce write = 0 in its output cycle.
REQ-026 When alu_valid is high, every queued entry with rd == alu_rd SHALL be invalidated; its pop later SHALL produce write = 0.
REQ-027 A load pushed in the same cycle with ld_rd == alu_rd (alu_valid high) SHALL be stored already invalidated.
REQ-028 Invalidated entries SHALL still occupy a slot and pop in order.
REQ-029 chk_pending SHALL be combinational: high iff chk_rd != 0 and any valid, non-invalidated queued entry has rd == chk_rd.
REQ-030 When write = 0, regwriteaddress and datain SHALL be 0.

Reset
REQ-031 While rst is high at a rising edge, count SHALL become 0, all entries invalid, and write, regwriteaddress and datain SHALL become 0.
REQ-032 Reset mid-operation SHALL discard all queued entries without emitting them; ld_ready SHALL be 1 in the first cycle after reset.
REQ-033 In any cycle where rst is high, inputs SHALL be ignored (no push, no pop).

Verification
REQ-034 ALU only: alu_valid=1, alu_rd=3, alu_data=0xAA at cycle N -> write=1, regwriteaddress=3, datain=0xAA at N+1.
REQ-035 Load collision: load rd=7, data=0x55 pushed at N, alu_valid held high N..N+2 -> load write appears at N+4; ld_ready falls to 0 after a second push.
REQ-036 Stale load: load rd=9 queued, then alu_valid, alu_rd=9, data=1 -> reg 9 written with 1; the later load pop gives write=0; chk_pending(9)=0 after the ALU cycle.
REQ-037 x0: alu_rd=0, alu_data=0xFF -> write=0 the next cycle; load with ld_rd=0 pops with write=0.
REQ-038 Full FIFO plus reset: two loads queued, rst pulsed for one cycle -> count=0, ld_ready=1, and no write from the discarded entries.
REQ-039 Simultaneous push and pop: count=1, load pushed while the head pops (alu_valid=0) -> count stays 1 and results emerge in push order.

Source files
------------

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: ALU results win every cycle, load results
// wait in a small in-order queue and retire in cycles the ALU leaves free.
module writeback_unit #(
  parameter int DW     = 64,
  parameter int AW     = 5,
  parameter int QDEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_rd,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] chk_rd,
  output logic          chk_pending,
  output logic          write,
  output logic [AW-1:0] regwriteaddress,
  output logic [DW-1:0] datain
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [CW-1:0]     count_q, count_d;
  logic [QDEPTH-1:0] live_q, live_d;
  logic [AW-1:0]     ent_rd_q   [QDEPTH];
  logic [AW-1:0]     ent_rd_d   [QDEPTH];
  logic [DW-1:0]     ent_data_q [QDEPTH];
  logic [DW-1:0]     ent_data_d [QDEPTH];

  logic          write_q, write_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          push, pop;
  logic [CW-1:0] push_idx;

  assign ld_ready        = (count_q < CW'(QDEPTH));
  assign write           = write_q;
  assign regwriteaddress = waddr_q;
  assign datain          = wdata_q;

  always_comb begin
    chk_pending = 1'b0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if (CW'(i) < count_q && live_q[i] && ent_rd_q[i] == chk_rd && chk_rd != '0)
        chk_pending = 1'b1;
    end
  end

  always_comb begin
    pop      = !alu_valid && (count_q != '0);
    push     = ld_valid && ld_ready;
    push_idx = pop ? count_q - 1'b1 : count_q;

    live_d     = live_q;
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;

    // A younger ALU write makes any queued load to the same register stale.
    if (alu_valid) begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (CW'(i) < count_q && ent_rd_q[i] == alu_rd)
          live_d[i] = 1'b0;
      end
    end

    // Slot 0 is always the head; popping shifts the queue down by one.
    if (pop) begin
      for (int unsigned i = 0; i + 1 < QDEPTH; i++) begin
        live_d[i]     = live_q[i+1];
        ent_rd_d[i]   = ent_rd_q[i+1];
        ent_data_d[i] = ent_data_q[i+1];
      end
      live_d[QDEPTH-1]     = 1'b0;
      ent_rd_d[QDEPTH-1]   = '0;
      ent_data_d[QDEPTH-1] = '0;
    end

    if (push) begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (CW'(i) == push_idx) begin
          live_d[i]     = !(alu_valid && ld_rd == alu_rd);
          ent_rd_d[i]   = ld_rd;
          ent_data_d[i] = ld_data;
        end
      end
    end

    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;

    write_d = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    if (alu_valid) begin
      if (alu_rd != '0) begin
        write_d = 1'b1;
        waddr_d = alu_rd;
        wdata_d = alu_data;
      end
    end else if (pop && live_q[0] && ent_rd_q[0] != '0) begin
      write_d = 1'b1;
      waddr_d = ent_rd_q[0];
      wdata_d = ent_data_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      live_q  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        ent_rd_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
      write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      count_q    <= count_d;
      live_q     <= live_d;
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
      write_q    <= write_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios then random traffic, all
// checked against a queue-based reference model of the writeback rules.
module tb_writeback_unit;

  localparam int DW     = 64;
  localparam int AW     = 5;
  localparam int QDEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_data;
  logic [AW-1:0] chk_rd;
  logic          chk_pending;
  logic          write;
  logic [AW-1:0] regwriteaddress;
  logic [DW-1:0] datain;

  always #5 clk = ~clk;

  writeback_unit #(.DW(DW), .AW(AW), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .chk_rd(chk_rd), .chk_pending(chk_pending),
    .write(write), .regwriteaddress(regwriteaddress), .datain(datain)
  );

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    bit            live;
  } ent_t;

  ent_t q[$];
  int checks   = 0;
  int failures = 0;
  logic          e_w;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_d;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, clock, update the
  // model, then check the registered writeback.
  task automatic step(input logic r, input logic av, input logic [AW-1:0] ar,
                      input logic [DW-1:0] ad, input logic lv, input logic [AW-1:0] lr,
                      input logic [DW-1:0] ldd, input logic [AW-1:0] cr);
    bit exp_ready, exp_pend, acc;
    ent_t e;
    rst = r; alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid = lv; ld_rd = lr; ld_data = ldd; chk_rd = cr;
    #1;
    exp_ready = (q.size() < QDEPTH);
    exp_pend  = 1'b0;
    foreach (q[i]) if (q[i].live && q[i].rd == cr && cr != 0) exp_pend = 1'b1;
    check("ld_ready", DW'(ld_ready), DW'(exp_ready));
    check("chk_pending", DW'(chk_pending), DW'(exp_pend));
    @(posedge clk);
    e_w = 1'b0; e_a = '0; e_d = '0;
    if (r) begin
      q.delete();
    end else begin
      acc = lv && (q.size() < QDEPTH);
      if (av) begin
        foreach (q[i]) if (q[i].rd == ar) q[i].live = 1'b0;
        if (ar != 0) begin e_w = 1'b1; e_a = ar; e_d = ad; end
      end else if (q.size() > 0) begin
        e = q.pop_front();
        if (e.live && e.rd != 0) begin e_w = 1'b1; e_a = e.rd; e_d = e.data; end
      end
      if (acc) q.push_back('{rd: lr, data: ldd, live: !(av && lr == ar)});
    end
    #1;
    check("write", DW'(write), DW'(e_w));
    check("regwriteaddress", DW'(regwriteaddress), DW'(e_a));
    check("datain", datain, e_d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; chk_rd = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, then model and DUT track from here on.
    check("reset_write", DW'(write), 0);
    check("reset_ld_ready", DW'(ld_ready), 1);
    check("reset_datain", datain, 0);

    // ALU only
    step(0, 1, 3, 64'hAA, 0, 0, 0, 0);
    check("alu_only_write", DW'(write), 1);
    check("alu_only_addr", DW'(regwriteaddress), 3);
    check("alu_only_data", datain, 64'hAA);

    // Load held off by three ALU cycles, then a fill to full
    step(0, 1, 1, 64'h10, 1, 7, 64'h55, 7);
    step(0, 1, 2, 64'h11, 0, 0, 0, 7);
    step(0, 1, 4, 64'h12, 0, 0, 0, 7);
    step(0, 0, 0, 0, 0, 0, 0, 7);
    check("load_collision_data", datain, 64'h55);
    step(0, 1, 5, 64'h20, 1, 5, 64'h21, 0);
    step(0, 1, 6, 64'h22, 1, 6, 64'h23, 0);
    step(0, 1, 8, 64'h24, 1, 8, 64'h25, 0);
    check("full_ld_ready", DW'(ld_ready), 0);
    idle(3);

    // Stale load
    step(0, 0, 0, 0, 1, 9, 64'h99, 9);
    step(0, 1, 9, 64'h1, 0, 0, 0, 9);
    step(0, 0, 0, 0, 0, 0, 0, 9);
    check("stale_pop_write", DW'(write), 0);
    idle(1);

    // x0 handling
    step(0, 1, 0, 64'hFF, 1, 0, 64'h77, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Full FIFO then reset discards entries
    step(0, 1, 1, 64'h1, 1, 12, 64'hC0, 12);
    step(0, 1, 2, 64'h2, 1, 13, 64'hC1, 13);
    step(1, 1, 3, 64'h3, 1, 14, 64'hC2, 12);
    check("post_reset_ld_ready", DW'(ld_ready), 1);
    idle(3);

    // Simultaneous push and pop preserves order
    step(0, 1, 1, 64'h5, 1, 20, 64'hA0, 0);
    step(0, 0, 0, 0, 1, 21, 64'hA1, 21);
    step(0, 0, 0, 0, 0, 0, 0, 21);
    idle(2);

    // Random traffic with a small register range to force collisions
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 45),
           AW'($urandom_range(0, 7)), {$urandom, $urandom},
           ($urandom_range(0, 99) < 60),
           AW'($urandom_range(0, 7)), {$urandom, $urandom},
           AW'($urandom_range(0, 7)));
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
